// File: rtl/divisor_pkg.sv
// Shared constants and helpers for the programmable two-stage divider.
package divisor_pkg;

  localparam int DIV_WIDTH_DEF = 24;
  localparam int DIV_A_RST_DEF = 10000;
  localparam int DIV_B_RST_DEF = 100;

  // A divisor of zero behaves like one: the stage ticks on every enable.
  function automatic logic [31:0] norm_div(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/divisor_if.sv
// Control/status bundle of the divider: master drives en/load/divisors, slave returns ticks.
interface divisor_if #(
  parameter int DIV_WIDTH = 24
);
  logic                 en;
  logic                 load;
  logic [DIV_WIDTH-1:0] div_a_in;
  logic [DIV_WIDTH-1:0] div_b_in;
  logic                 tick_a;
  logic                 tick_b;
  logic                 sq_a;
  logic                 sq_b;
  logic                 pend;

  // load is a one-cycle strobe with no back-pressure: it is accepted on every
  // rising edge where it is high, and pend stays high until both stages apply it.
  modport master (
    output en, load, div_a_in, div_b_in,
    input  tick_a, tick_b, sq_a, sq_b, pend
  );

  modport slave (
    input  en, load, div_a_in, div_b_in,
    output tick_a, tick_b, sq_a, sq_b, pend
  );
endinterface

// File: rtl/divisor_stage.sv
// One divider stage: counter with active and pending divisor, tick and optional square output.
// Square-wave flop is present only when DIVISOR_SQ_EN is defined.
module divisor_stage
  import divisor_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF,
  parameter int RST_DIV   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stage_en,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] div_in,
  output logic                 tick,
  output logic                 sq,
  output logic                 pending
);

  localparam logic [DIV_WIDTH-1:0] N_RST = DIV_WIDTH'(norm_div(32'(RST_DIV)));

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] n;
  logic [DIV_WIDTH-1:0] p;
  logic                 term;

  // n is always stored normalised (>= 1), so n - 1 never wraps.
  assign term = (cnt == n - DIV_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      n       <= N_RST;
      p       <= N_RST;
      pending <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (stage_en) begin
        if (term) begin
          cnt  <= '0;
          tick <= 1'b1;
          if (pending) begin
            n       <= DIV_WIDTH'(norm_div(32'(p)));
            pending <= 1'b0;
          end
        end else begin
          cnt <= cnt + DIV_WIDTH'(1);
        end
      end
      // A load on the wrap cycle lands after the swap, so it waits for the next wrap.
      if (load) begin
        p       <= div_in;
        pending <= 1'b1;
      end
    end
  end

`ifdef DIVISOR_SQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sq <= 1'b0;
    end else if (stage_en && term) begin
      sq <= ~sq;
    end
  end
`else
  assign sq = 1'b0;
`endif

endmodule

// File: rtl/divisor_prog.sv
// Programmable two-stage synchronous divider: stage A counts enabled clocks, stage B counts A ticks.
// Square-wave outputs are built only when DIVISOR_SQ_EN is defined.
module divisor_prog
  import divisor_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF,
  parameter int DIV_A_RST = DIV_A_RST_DEF,
  parameter int DIV_B_RST = DIV_B_RST_DEF
) (
  input logic      clk,
  input logic      rst,
  divisor_if.slave bus
);

  logic pend_a;
  logic pend_b;
  logic en_b;

  assign en_b = bus.tick_a & bus.en;

  divisor_stage #(
    .DIV_WIDTH (DIV_WIDTH),
    .RST_DIV   (DIV_A_RST)
  ) u_stage_a (
    .clk      (clk),
    .rst      (rst),
    .stage_en (bus.en),
    .load     (bus.load),
    .div_in   (bus.div_a_in),
    .tick     (bus.tick_a),
    .sq       (bus.sq_a),
    .pending  (pend_a)
  );

  divisor_stage #(
    .DIV_WIDTH (DIV_WIDTH),
    .RST_DIV   (DIV_B_RST)
  ) u_stage_b (
    .clk      (clk),
    .rst      (rst),
    .stage_en (en_b),
    .load     (bus.load),
    .div_in   (bus.div_b_in),
    .tick     (bus.tick_b),
    .sq       (bus.sq_b),
    .pending  (pend_b)
  );

  assign bus.pend = pend_a | pend_b;

endmodule

// File: tb/tb_divisor_prog.sv
// Self-checking bench for divisor_prog: per-cycle expected outputs from a reference model, checked by a monitor.
module tb_divisor_prog;
  localparam int W  = 24;
  localparam int NA = 4;
  localparam int NB = 3;

  logic clk;
  logic rst;

  divisor_if #(.DIV_WIDTH(W)) bus ();

  divisor_prog #(
    .DIV_WIDTH (W),
    .DIV_A_RST (NA),
    .DIV_B_RST (NB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: {tick_a, tick_b, sq_a, sq_b, pend}
  logic [4:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  // reference model: enabled cycles elapsed in the current period per stage
  int m_ca, m_cb, m_na, m_nb, m_pa, m_pb;
  bit m_fa, m_fb, m_ta, m_tb, m_sa, m_sb;

  task automatic model_step(input bit r, input bit e, input bit l, input int da, input int db);
    bit eb;
    if (r) begin
      m_ca = 0; m_cb = 0; m_na = NA; m_nb = NB;
      m_fa = 0; m_fb = 0; m_ta = 0; m_tb = 0; m_sa = 0; m_sb = 0;
    end else begin
      eb = m_ta && e;
      m_ta = 0;
      m_tb = 0;
      if (e) begin
        if (m_ca + 1 >= m_na) begin
          m_ca = 0; m_ta = 1; m_sa = ~m_sa;
          if (m_fa) begin m_na = (m_pa == 0) ? 1 : m_pa; m_fa = 0; end
        end else m_ca++;
      end
      if (eb) begin
        if (m_cb + 1 >= m_nb) begin
          m_cb = 0; m_tb = 1; m_sb = ~m_sb;
          if (m_fb) begin m_nb = (m_pb == 0) ? 1 : m_pb; m_fb = 0; end
        end else m_cb++;
      end
      if (l) begin
        m_pa = da; m_pb = db; m_fa = 1; m_fb = 1;
      end
    end
  endtask

  function automatic logic [4:0] model_out();
    logic sa, sb;
`ifdef DIVISOR_SQ_EN
    sa = m_sa; sb = m_sb;
`else
    sa = 1'b0; sb = 1'b0;
`endif
    return {m_ta, m_tb, sa, sb, m_fa | m_fb};
  endfunction

  // driver
  task automatic step(input bit r, input bit e, input bit l, input int da, input int db);
    @(negedge clk);
    rst          = r;
    bus.en       = e;
    bus.load     = l;
    bus.div_a_in = W'(da);
    bus.div_b_in = W'(db);
    model_step(r, e, l, da, db);
    exp_q.push_back(model_out());
  endtask

  task automatic run(input int cycles, input bit e);
    for (int i = 0; i < cycles; i++) step(0, e, 0, 0, 0);
  endtask

  // monitor
  initial begin
    logic [4:0] exp_v, act_v;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {bus.tick_a, bus.tick_b, bus.sq_a, bus.sq_b, bus.pend};
        n_checks++;
        if (act_v !== exp_v) begin
          n_fail++;
          if (n_fail <= 30)
            $display("FAIL outputs cycle %0d: got {ta,tb,sa,sb,pend}=%b expected %b", cycle, act_v, exp_v);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; bus.en = 1'b0; bus.load = 1'b0; bus.div_a_in = '0; bus.div_b_in = '0;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);

    // defaults: period 4, tick_b every 3rd tick_a
    run(40, 1);

    // load 6 at cnt_a == 1: current period stays 4
    for (int i = 0; i < 20 && m_ca != 1; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 6, 3);
    run(60, 1);

    // load on the wrap cycle of stage A
    for (int i = 0; i < 20 && m_ca != m_na - 1; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 5, 2);
    run(40, 1);

    // divisor 0: tick every enabled cycle once applied
    step(0, 1, 1, 0, 2);
    run(20, 1);

    // en low for 5 cycles mid-count
    step(0, 1, 1, 3, 2);
    run(12, 1);
    for (int i = 0; i < 20 && m_ca != 1; i++) step(0, 1, 0, 0, 0);
    run(5, 0);
    run(12, 1);

    // rst mid-count with a load pending
    step(0, 1, 1, 7, 4);
    run(1, 1);
    step(1, 1, 0, 0, 0);
    run(30, 1);

    // randomized traffic
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 7), $urandom_range(0, 4));

    @(negedge clk);
    bus.load = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/divisor_prog.md
# divisor_prog

Programmable two-stage frequency divider for the clock (reloj) datapath. It replaces fixed ripple-clocked decade chains with a fully synchronous counter pair. The counters produce single-cycle clock-enable ticks and optional square waves. Stage A derives the display/scan rate (default 100 Hz from 1 MHz); stage B derives the timekeeping rate (default 1 Hz). Both divisors can be reloaded at run time without glitches.

## Interface
- DIV_WIDTH, 24, width of each divisor and counter
- DIV_A_RST, 10000, stage A divisor after reset
- DIV_B_RST, 100, stage B divisor after reset
- clk  in  1  master clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- en  in  1  global count enable; low freezes both counters
- load  in  1  one-cycle strobe; captures div_a_in/div_b_in as pending divisors
- div_a_in  in  DIV_WIDTH  new stage A divisor
- div_b_in  in  DIV_WIDTH  new stage B divisor
- tick_a  out  1  one-cycle pulse every N_A enabled clk cycles
- tick_b  out  1  one-cycle pulse every N_B tick_a pulses
- sq_a  out  1  square wave, clk/(2·N_A)
- sq_b  out  1  square wave, toggles on each tick_b
- pend  out  1  high while any loaded divisor is not yet applied

## Operation
- Each stage has:
  - counter cnt (0..N−1)
  - active divisor N
  - pending divisor P and pending flag
- Divisor value 0 is treated as 1, so the stage ticks on every enable.
- Stage step, evaluated when the stage enable is high:
  - If cnt == N−1: cnt←0 and tick←1.
  - Otherwise: cnt←cnt+1 and tick←0.
- When the stage enable is low: cnt holds and tick←0.
- Stage A enable = en. Stage B enable = tick_a (registered) AND en.
- Square outputs: sq_x toggles in the same cycle tick_x is registered high.
- Load handling:
  - load captures div_a_in→P_A and div_b_in→P_B, and sets both pending flags.
  - At a stage's next terminal count, N←P and that flag clears. The wrapping count still uses the old N.
  - pend = OR of the two flags.
- If load coincides with a stage's terminal count, the old N governs that wrap. The new value applies at the following terminal count.
- A second load before application overwrites P. The last load wins.
- Counter arithmetic is unsigned DIV_WIDTH. Compare against N−1 computed on the normalised N≥1, so there is no wrap at 0.

## Timing
- Reset values:
  - cnt_a = cnt_b = 0
  - N_A = DIV_A_RST, N_B = DIV_B_RST
  - tick_a, tick_b, sq_a, sq_b, pend all 0
- rst asserted at any time, including mid-count or with a load pending, forces the reset values on the next edge. Pending divisors are discarded.
- First tick_a: high for exactly one cycle after the N_A-th enabled rising edge following reset release.
- tick_b: high one cycle after the tick_a pulse that completes stage B's count. Latency from that tick_a is one cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- en low for k cycles stretches the tick period by exactly k cycles. It has no effect on phase otherwise.

## Configuration
- DIVISOR_SQ_EN defined: sq_a and sq_b toggle flops are present as described.
- DIVISOR_SQ_EN undefined: the toggle flops are removed and sq_a and sq_b are tied to 0. Tick behaviour is identical.

## Structure
- Package divisor_pkg holds:
  - default DIV_WIDTH
  - reset divisor constants (DIV_A_RST, DIV_B_RST)
  - a normalisation function (0→1)
- Sub-module divisor_stage: one counter with active/pending divisor, stage enable in, tick/sq out, pending flag out. It is instantiated twice. The top level only wires enables, load fan-out and the pend OR.

## Test plan
- Reset release, defaults, en=1 → tick_a pulses exactly every 10000 cycles, first after edge 10000; tick_b every 1,000,000 cycles.
- DIV_A_RST=4, DIV_B_RST=3 → tick_a period 4 cycles; tick_b once per 3 tick_a, lagging 1 cycle; sq_a period 8 (DIVISOR_SQ_EN set) or constant 0 (unset).
- load div_a_in=6 at cnt_a=1 with N_A=4 → current period stays 4 and subsequent periods are 6; pend drops after stage B also wraps.
- load in the same cycle as a stage A terminal count → that wrap uses old N, and the new N applies from the following period.
- div_a_in=0 loaded → after application, tick_a high every enabled cycle.
- en low for 5 cycles mid-count, then rst pulse mid-count with load pending → period stretched by 5; after rst all outputs 0 and counting restarts with reset divisors.
